logic_serial_unit: RTL and testbench



---
 rtl/alu_logic_pkg.sv | 28 ++
 rtl/logic_serial_unit_if.sv | 22 ++
 rtl/logic_serial_unit_bit_slice.sv | 13 +
 rtl/logic_serial_unit.sv | 94 +++++++++
 tb/tb_logic_serial_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/alu_logic_pkg.sv
// Shared definitions for the ALU logical datapath: opcodes, serial-unit states
// and the single-bit evaluation rule used by both serial and parallel paths.
package alu_logic_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic logic_op(input logic [1:0] op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_serial_unit_if.sv
// Command and result handshakes of the bit-serial logical unit.
interface logic_serial_unit_if #(parameter int unsigned WIDTH = 4);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, op, x, y, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, op, x, y, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/logic_serial_unit_bit_slice.sv
// Combinational 1-bit logical evaluator fed by the serial unit's bit selector.
module logic_bit_slice
  import alu_logic_pkg::*;
(
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  output logic       r
);

  assign r = logic_op(op, a, b);

endmodule

// File: rtl/logic_serial_unit.sv
// Bit-serial logical unit: accepts one command, evaluates LSB first one bit per
// clock, then holds result/zero on the output handshake until consumed.
module logic_serial_unit
  import alu_logic_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic clk,
  input logic rst,
  logic_serial_unit_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] x_q, y_q, sr, res_q;
  logic [WIDTH-1:0] word;
  logic             zero_q;
  logic [CW-1:0]    cnt;
  logic             bit_r;
  logic             accept, last;
  logic             in_ready_c, out_valid_c;

  logic_bit_slice u_slice (
    .op (op_q),
    .a  (x_q[cnt]),
    .b  (y_q[cnt]),
    .r  (bit_r)
  );

  assign accept = bus.in_valid && in_ready_c;
  assign last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  // New bit enters at the MSB; after WIDTH shifts the first bit sits at the LSB.
  assign word   = {bit_r, sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE:    in_ready_c  = 1'b1;
      DONE:    out_valid_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      sr     <= '0;
      cnt    <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        op_q <= bus.op;
        x_q  <= bus.x;
        y_q  <= bus.y;
        sr   <= '0;
        cnt  <= '0;
      end
    end else if (state == SHIFT) begin
      sr  <= word;
      cnt <= cnt + CW'(1);
      if (last) begin
        res_q  <= word;
        zero_q <= (word == '0);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_logic_serial_unit.sv
// Scoreboard bench for logic_serial_unit at WIDTH=4.
module tb_logic_serial_unit;
  import alu_logic_pkg::*;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_serial_unit_if #(.WIDTH(W)) bus ();

  logic_serial_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned last_acc = 0;
  int unsigned prev_acc = 0;
  logic [W:0]  sb[$];
  logic        ov_prev = 1'b0;
  logic        rdy_chk = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (o)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~a;
    endcase
    return {(r == '0), r};
  endfunction

  // Output side: compare each consumed result against the scoreboard.
  always @(negedge clk) begin
    logic [W:0] e;
    if (rst) begin
      ov_prev = 1'b0;
      rdy_chk = 1'b0;
    end else begin
      if (rdy_chk) begin
        check("in_ready_after_pop", bus.in_ready, 1);
        rdy_chk = 1'b0;
      end
      if (bus.out_valid && !ov_prev) check("latency", cyc - last_acc, W);
      if (bus.out_valid && bus.out_ready) begin
        check("no_bypass", bus.in_ready, 0);
        if (sb.size() == 0) check("spurious_out", 1, 0);
        else begin
          e = sb.pop_front();
          check("result", bus.result, e[W-1:0]);
          check("zero", bus.zero, e[W]);
        end
        rdy_chk = 1'b1;
      end
      ov_prev = bus.out_valid;
    end
  end

  // Called and returns at posedge+1.
  task automatic send(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned n = 0;
    bus.op = o; bus.x = a; bus.y = b; bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      @(posedge clk); #1;
      prev_acc = last_acc;
      last_acc = cyc;
      sb.push_back(model(o, a, b));
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned n;
    bus.in_valid = 1'b0; bus.op = '0; bus.x = '0; bus.y = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_zero", bus.zero, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(OP_OR, 4'b1010, 4'b0101);
    drain();

    send(OP_AND, 4'b1100, 4'b1010);
    send(OP_XOR, 4'b1111, 4'b1111);
    check("spacing", last_acc - prev_acc, W + 2);
    drain();

    send(OP_NOT, 4'b0011, 4'b1111);
    drain();

    // Backpressure with a competing command held on in_valid.
    bus.out_ready = 1'b0;
    send(OP_XOR, 4'b0110, 4'b0011);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("bp_wait", bus.out_valid, 1);
    bus.in_valid = 1'b1; bus.op = OP_AND; bus.x = '0; bus.y = '0;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_result", bus.result, 4'b0101);
      check("bp_zero", bus.zero, 0);
      check("bp_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    repeat (6) @(posedge clk);
    #1;

    send(OP_OR, 4'b0001, 4'b0000);
    bus.x = 4'b1111; bus.y = 4'b1111;
    drain();

    // Reset two cycles into SHIFT discards the command.
    send(OP_AND, 4'b1111, 4'b1111);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_back());
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_result", bus.result, 0);
    check("abort_zero", bus.zero, 0);
    repeat (8) @(posedge clk);
    #1;
    send(OP_OR, 4'b0000, 4'b0000);
    drain();

    for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
